// File: rtl/read_capture_pkg.sv
// Shared types and constants for the read capture block: FSM states,
// default geometry and the frame length field width.
package read_capture_pkg;

    localparam int DW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 8;
    localparam int LEN_W         = 4;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        CLOSE = 2'd2
    } state_e;

endpackage

// File: rtl/read_capture_fifo.sv
// Synchronous FIFO with a registered head-of-queue output; pointers carry one
// extra wrap bit so full and empty are distinguished without a counter.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          do_push, do_pop;

    assign empty   = (rd_ptr_q == wr_ptr_q);
    assign full    = (rd_ptr_q[AW] != wr_ptr_q[AW]) &&
                     (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = dout_q;

    // The head register is preloaded with the word that will be oldest after
    // this cycle; a push into an otherwise empty queue is forwarded directly.
    always_comb begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        dout_d   = dout_q;
        if (rd_ptr_d != wr_ptr_d) begin
            if (do_push && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
                dout_d = din;
            end else begin
                dout_d = mem[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/read_capture.sv
// Captures read data words into a FIFO and tracks frame boundaries from the
// upstream sequencer's busy and done strobes, reporting per-frame word counts.
module read_capture
    import read_capture_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd,
    input  logic             ds,
    input  logic [DW-1:0]    din,
    input  logic             din_vld,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_done,
    output logic             frame_abort,
    output logic             overflow
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             ovf_q;
    logic             push_req, pop, accept, drop;
    logic             full, empty;

    assign push_req = rd & din_vld & ~ds;
    assign pop      = dout_valid & dout_ready;
    assign accept   = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign cnt_inc  = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + 1'b1;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    assign dout_valid  = ~empty;
    assign frame_len   = len_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign overflow    = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ds) begin
                    state_d = CLOSE;
                end else if (rd) begin
                    state_d = CAPT;
                    if (accept) cnt_d = cnt_inc;
                end
            end
            CAPT: begin
                if (ds) begin
                    state_d = CLOSE;
                end else if (!rd) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_inc;
                end
            end
            CLOSE: begin
                // A push in the closing cycle already belongs to the next frame.
                len_d  = cnt_q;
                done_d = 1'b1;
                cnt_d  = '0;
                if (rd) begin
                    state_d = CAPT;
                    if (accept) cnt_d = LEN_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            if (drop) ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_read_capture.sv
// Self-checking bench for read_capture: directed frame scenarios plus a
// randomized run compared against a queue-based frame model.
module tb_read_capture;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0, rd = 1'b0, ds = 1'b0, din_vld = 1'b0, dout_ready = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [3:0]    frame_len;
    logic          frame_done, frame_abort, overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] popped[$];
    int            m_words;
    bit            m_open, m_closing, m_done, m_abort, m_ovf;
    logic [3:0]    m_len;
    int            done_seen, abort_seen;

    read_capture #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd          (rd),
        .ds          (ds),
        .din         (din),
        .din_vld     (din_vld),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .frame_len   (frame_len),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input logic s_rst, s_rd, s_ds, input logic [DW-1:0] s_din,
                        input logic s_vld, s_rdy);
        bit push_req, pop, acc;
        rst = s_rst; rd = s_rd; ds = s_ds; din = s_din; din_vld = s_vld; dout_ready = s_rdy;
        if (!s_rst && dout_valid === 1'b1 && s_rdy) popped.push_back(dout);
        @(posedge clk);
        if (s_rst) begin
            m_q.delete();
            m_words = 0; m_open = 0; m_closing = 0;
            m_done = 0; m_abort = 0; m_ovf = 0; m_len = '0;
        end else begin
            push_req = s_rd && s_vld && !s_ds;
            pop      = (m_q.size() > 0) && s_rdy;
            acc      = push_req && ((m_q.size() < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(s_din);
            if (push_req && !acc) m_ovf = 1;
            m_done = 0; m_abort = 0;
            if (m_closing) begin
                m_len     = (m_words > 15) ? 4'd15 : 4'(m_words);
                m_done    = 1;
                m_closing = 0;
                m_open    = s_rd;
                m_words   = acc ? 1 : 0;
            end else if (s_ds) begin
                m_closing = 1;
                m_open    = 0;
            end else if (m_open && !s_rd) begin
                m_abort = 1;
                m_open  = 0;
                m_words = 0;
            end else if (s_rd) begin
                m_open = 1;
                if (acc) m_words++;
            end
        end
        #1;
        if (frame_done === 1'b1) done_seen++;
        if (frame_abort === 1'b1) abort_seen++;
    endtask

    task automatic do_reset();
        step(1, 0, 0, '0, 0, 0);
        rst = 1'b0;
        popped.delete();
        done_seen = 0;
        abort_seen = 0;
    endtask

    task automatic test_reset();
        step(1, 1, 0, 8'h5A, 1, 0);
        total_cnt++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", dout_valid); else pass_cnt++;
        total_cnt++; if (dout !== 8'h00) $display("FAIL reset_dout: got %02h want 00", dout); else pass_cnt++;
        total_cnt++; if (frame_len !== 4'd0) $display("FAIL reset_len: got %0d want 0", frame_len); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", frame_done); else pass_cnt++;
        total_cnt++; if (frame_abort !== 1'b0) $display("FAIL reset_abort: got %0b want 0", frame_abort); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", overflow); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_w [3] = '{8'h11, 8'h22, 8'h33};
        logic [DW-1:0] got;
        do_reset();
        step(0, 1, 0, 8'h11, 1, 0);
        step(0, 1, 0, 8'h22, 1, 0);
        step(0, 1, 0, 8'h33, 1, 0);
        step(0, 1, 1, 8'h00, 0, 0);
        step(0, 0, 0, 8'h00, 0, 0);
        total_cnt++; if (frame_done !== 1'b1) $display("FAIL basic_done: got %0b want 1", frame_done); else pass_cnt++;
        total_cnt++; if (frame_len !== 4'd3) $display("FAIL basic_len: got %0d want 3", frame_len); else pass_cnt++;
        repeat (5) step(0, 0, 0, 8'h00, 0, 1);
        total_cnt++; if (done_seen != 1) $display("FAIL basic_done_count: got %0d want 1", done_seen); else pass_cnt++;
        total_cnt++; if (popped.size() != 3) $display("FAIL basic_drain_size: got %0d want 3", popped.size()); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            got = (i < popped.size()) ? popped[i] : 8'hxx;
            total_cnt++; if (got !== exp_w[i]) $display("FAIL basic_order[%0d]: got %02h want %02h", i, got, exp_w[i]); else pass_cnt++;
        end
        $display("test_basic done");
    endtask

    task automatic test_overflow();
        logic [DW-1:0] got;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, 8'(i + 1), 1, 0);
            if (i == 7) begin
                total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_after8: got %0b want 0", overflow); else pass_cnt++;
            end
        end
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_after9: got %0b want 1", overflow); else pass_cnt++;
        step(0, 1, 1, 8'h00, 0, 0);
        step(0, 0, 0, 8'h00, 0, 0);
        total_cnt++; if (frame_len !== 4'd8) $display("FAIL ovf_len: got %0d want 8", frame_len); else pass_cnt++;
        repeat (12) step(0, 0, 0, 8'h00, 0, 1);
        total_cnt++; if (popped.size() != 8) $display("FAIL ovf_drain_size: got %0d want 8", popped.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            got = (i < popped.size()) ? popped[i] : 8'hxx;
            total_cnt++; if (got !== 8'(i + 1)) $display("FAIL ovf_order[%0d]: got %02h want %02h", i, got, 8'(i + 1)); else pass_cnt++;
        end
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", overflow); else pass_cnt++;
        $display("test_overflow done");
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] got, exp_v;
        int            full_gaps;
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(64 + i), 1, 0);
        full_gaps = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 8'(80 + i), 1, 1);
            if (dout_valid !== 1'b1) full_gaps++;
        end
        total_cnt++; if (full_gaps != 0) $display("FAIL fullpop_valid: got %0d empty cycles want 0", full_gaps); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf: got %0b want 0", overflow); else pass_cnt++;
        step(0, 1, 1, 8'h00, 0, 0);
        step(0, 0, 0, 8'h00, 0, 0);
        total_cnt++; if (frame_len !== 4'd13) $display("FAIL fullpop_len: got %0d want 13", frame_len); else pass_cnt++;
        repeat (12) step(0, 0, 0, 8'h00, 0, 1);
        total_cnt++; if (popped.size() != 13) $display("FAIL fullpop_drain_size: got %0d want 13", popped.size()); else pass_cnt++;
        for (int i = 0; i < 13; i++) begin
            exp_v = (i < 8) ? 8'(64 + i) : 8'(80 + i - 8);
            got   = (i < popped.size()) ? popped[i] : 8'hxx;
            total_cnt++; if (got !== exp_v) $display("FAIL fullpop_order[%0d]: got %02h want %02h", i, got, exp_v); else pass_cnt++;
        end
        $display("test_full_pop done");
    endtask

    task automatic test_abort();
        logic [DW-1:0] got;
        do_reset();
        step(0, 1, 0, 8'hA1, 1, 0);
        step(0, 1, 0, 8'hA2, 1, 0);
        step(0, 0, 0, 8'h00, 0, 0);
        total_cnt++; if (frame_abort !== 1'b1) $display("FAIL abort_pulse: got %0b want 1", frame_abort); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL abort_done: got %0b want 0", frame_done); else pass_cnt++;
        step(0, 0, 0, 8'h00, 0, 0);
        total_cnt++; if (frame_abort !== 1'b0) $display("FAIL abort_width: got %0b want 0", frame_abort); else pass_cnt++;
        repeat (4) step(0, 0, 0, 8'h00, 0, 1);
        total_cnt++; if (popped.size() != 2) $display("FAIL abort_drain_size: got %0d want 2", popped.size()); else pass_cnt++;
        got = (popped.size() > 0) ? popped[0] : 8'hxx;
        total_cnt++; if (got !== 8'hA1) $display("FAIL abort_word0: got %02h want a1", got); else pass_cnt++;
        got = (popped.size() > 1) ? popped[1] : 8'hxx;
        total_cnt++; if (got !== 8'hA2) $display("FAIL abort_word1: got %02h want a2", got); else pass_cnt++;
        total_cnt++; if (done_seen != 0 || abort_seen != 1) $display("FAIL abort_pulses: got done=%0d abort=%0d want done=0 abort=1", done_seen, abort_seen); else pass_cnt++;
        $display("test_abort done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(0, 1, 0, 8'h01, 1, 0);
        step(0, 1, 0, 8'h02, 1, 0);
        step(0, 1, 1, 8'h00, 0, 1);
        step(0, 0, 0, 8'h00, 0, 1);
        total_cnt++; if (frame_len !== 4'd2) $display("FAIL rstmid_first_len: got %0d want 2", frame_len); else pass_cnt++;
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(16 + i), 1, 0);
        total_cnt++; if (dout_valid !== 1'b1) $display("FAIL rstmid_buffered: got %0b want 1", dout_valid); else pass_cnt++;
        step(1, 1, 0, 8'hEE, 1, 0);
        rst = 1'b0;
        done_seen = 0;
        abort_seen = 0;
        total_cnt++; if (dout_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", dout_valid); else pass_cnt++;
        total_cnt++; if (frame_len !== 4'd0) $display("FAIL rstmid_len: got %0d want 0", frame_len); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0 || frame_abort !== 1'b0) $display("FAIL rstmid_pulse: got done=%0b abort=%0b want 0 0", frame_done, frame_abort); else pass_cnt++;
        repeat (2) step(0, 0, 0, 8'h00, 0, 1);
        total_cnt++; if (done_seen != 0 || abort_seen != 0) $display("FAIL rstmid_late_pulse: got done=%0d abort=%0d want 0 0", done_seen, abort_seen); else pass_cnt++;
        total_cnt++; if (dout_valid !== 1'b0) $display("FAIL rstmid_still_empty: got %0b want 0", dout_valid); else pass_cnt++;
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(i + 1), 1, 1);
        step(0, 1, 1, 8'h00, 0, 1);
        step(0, 1, 0, 8'h80, 1, 1);
        total_cnt++; if (frame_done !== 1'b1) $display("FAIL b2b_done1: got %0b want 1", frame_done); else pass_cnt++;
        total_cnt++; if (frame_len !== 4'd3) $display("FAIL b2b_len1: got %0d want 3", frame_len); else pass_cnt++;
        for (int i = 0; i < 19; i++) step(0, 1, 0, 8'(129 + i), 1, 1);
        step(0, 1, 1, 8'h00, 0, 1);
        step(0, 0, 0, 8'h00, 0, 1);
        total_cnt++; if (frame_done !== 1'b1) $display("FAIL b2b_done2: got %0b want 1", frame_done); else pass_cnt++;
        total_cnt++; if (frame_len !== 4'd15) $display("FAIL b2b_len2: got %0d want 15", frame_len); else pass_cnt++;
        repeat (3) step(0, 0, 0, 8'h00, 0, 1);
        total_cnt++; if (popped.size() != 23) $display("FAIL b2b_drain_size: got %0d want 23", popped.size()); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0 || done_seen != 2) $display("FAIL b2b_flags: got ovf=%0b done=%0d want 0 2", overflow, done_seen); else pass_cnt++;
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        logic          r_rst, r_rd, r_ds, r_vld, r_rdy;
        logic [DW-1:0] r_din;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_rd  = ($urandom_range(0, 9) < 8);
            r_ds  = ($urandom_range(0, 19) == 0);
            r_vld = ($urandom_range(0, 9) < 7);
            r_rdy = ($urandom_range(0, 1) == 1);
            r_din = 8'($urandom);
            step(r_rst, r_rd, r_ds, r_din, r_vld, r_rdy);
            total_cnt++; if (dout_valid !== (m_q.size() > 0)) $display("FAIL rand_valid @%0d: got %0b want %0b", n, dout_valid, m_q.size() > 0); else pass_cnt++;
            if (m_q.size() > 0) begin
                total_cnt++; if (dout !== m_q[0]) $display("FAIL rand_dout @%0d: got %02h want %02h", n, dout, m_q[0]); else pass_cnt++;
            end
            total_cnt++; if (frame_len !== m_len) $display("FAIL rand_len @%0d: got %0d want %0d", n, frame_len, m_len); else pass_cnt++;
            total_cnt++; if (frame_done !== m_done) $display("FAIL rand_done @%0d: got %0b want %0b", n, frame_done, m_done); else pass_cnt++;
            total_cnt++; if (frame_abort !== m_abort) $display("FAIL rand_abort @%0d: got %0b want %0b", n, frame_abort, m_abort); else pass_cnt++;
            total_cnt++; if (overflow !== m_ovf) $display("FAIL rand_ovf @%0d: got %0b want %0b", n, overflow, m_ovf); else pass_cnt++;
        end
        rst = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/read_capture.md
READ_CAPTURE -- requirements
Module: read_capture

Interface
REQ-001 SHALL have parameter DW, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, buffer depth in words; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rd, input, 1, read-busy from the upstream read sequencer; high from READ through DONE.
REQ-006 SHALL have port ds, input, 1, done strobe from the upstream sequencer; single-cycle frame-end marker.
REQ-007 SHALL have port din, input, DW, read data word.
REQ-008 SHALL have port din_vld, input, 1, din qualifier.
REQ-009 SHALL have port dout, output, DW, head-of-buffer word.
REQ-010 SHALL have port dout_valid, output, 1, buffer not empty.
REQ-011 SHALL have port dout_ready, input, 1, consumer accepts dout this cycle.
REQ-012 SHALL have port frame_len, output, 4, accepted-word count of the last closed frame.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse when frame_len updates.
REQ-014 SHALL have port frame_abort, output, 1, one-cycle pulse when a frame ends without ds.
REQ-015 SHALL have port overflow, output, 1, sticky flag set when a word is dropped.

Function
REQ-016 SHALL define push_req = rd & din_vld & ~ds, and pop = dout_valid & dout_ready.
REQ-017 SHALL accept a push when not full, or when full with pop in the same cycle; otherwise drop the word and set overflow.
REQ-018 SHALL keep the buffer FIFO-ordered; dout is the oldest word, registered, and valid in the same cycle dout_valid is high.
REQ-019 SHALL ignore pop when empty; on simultaneous push and pop when empty, dout_valid rises next cycle with the pushed word.
REQ-020 SHALL implement states IDLE, CAPT and CLOSE.
REQ-021 SHALL go IDLE->CAPT when rd=1, counting a push in that same cycle.
REQ-022 SHALL go CAPT->CLOSE on ds=1.
REQ-023 SHALL go CAPT->IDLE on rd=0 with ds=0, pulsing frame_abort next cycle and clearing the word counter.
REQ-024 SHALL stay in CAPT otherwise.
REQ-025 SHALL, in CLOSE, load frame_len from the word counter, pulse frame_done, and clear the counter.
REQ-026 SHALL leave CLOSE for CAPT if rd=1 (new frame; a push that cycle counts toward it), else for IDLE.
REQ-027 SHALL count accepted pushes only in the word counter, saturating at 15.
REQ-028 SHALL treat ds received in IDLE as a zero-length frame: go to CLOSE, then frame_len=0 and frame_done pulses.
REQ-029 SHALL never drain or flush buffer contents on frame abort.
REQ-030 SHALL clear overflow only on rst.
REQ-031 SHALL manage pointers with DEPTH wrap plus one extra wrap bit; full = pointers equal except wrap bit.

Reset
REQ-032 SHALL, on rst: state=IDLE, buffer empty, dout_valid=0, dout=0, frame_len=0, frame_done=0, frame_abort=0, overflow=0, counter=0.
REQ-033 SHALL let rst override all other inputs in the same cycle, including mid-frame and when the buffer is full; no pulse is emitted for the cut frame.

Structure
REQ-034 SHALL place the state enum (IDLE, CAPT, CLOSE), default DW/DEPTH constants and the 4-bit length width in package read_capture_pkg.
REQ-035 SHALL put the buffer in sub-module sync_fifo (push, pop, full, empty, data); the FSM, counter and flags live in read_capture.

Verification
REQ-036 SHALL check: rst, then rd=1 for 3 cycles with din_vld=1 and din=0x11,0x22,0x33, then ds=1 -> frame_done one pulse, frame_len=3, dout order 0x11,0x22,0x33.
REQ-037 SHALL check: dout_ready=0 and 9 valid words in one frame (DEPTH=8) -> overflow=1 after 9th, frame_len=8, ninth word absent from dout.
REQ-038 SHALL check: buffer full and dout_ready=1 while pushing -> no overflow, occupancy stays 8, order preserved.
REQ-039 SHALL check: 2 words, then rd drops with no ds -> frame_abort pulse, frame_done stays 0, both words still drain.
REQ-040 SHALL check: rst asserted mid-frame with 4 words buffered -> next cycle dout_valid=0, frame_len=0, no frame_done or frame_abort.
REQ-041 SHALL check: ds then rd high immediately -> CLOSE->CAPT, frame_len of first frame correct, second frame counts from 0 and reports 20 words as 15.
